// File: rtl/operand_feeder.sv
// Stimulus stage for a registered single-operator block: issues an LCG operand
// stream, samples the operator result after LATENCY cycles and folds it into a signature.
module operand_feeder #(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      NUM_VECTORS = 256,
    parameter int unsigned      LATENCY     = 2,
    parameter logic [WIDTH-1:0] SEED_A      = WIDTH'(1),
    parameter logic [WIDTH-1:0] SEED_B      = WIDTH'(2)
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               start,
    output logic [WIDTH-1:0]                   dataa,
    output logic [WIDTH-1:0]                   datab,
    input  logic [WIDTH-1:0]                   result,
    output logic                               busy,
    output logic                               done,
    output logic [WIDTH-1:0]                   signature,
    output logic [$clog2(NUM_VECTORS+1)-1:0]   vec_count
);

    localparam int unsigned CNT_W = $clog2(NUM_VECTORS + 1);
    localparam int unsigned DRN_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_dataa;
    logic [WIDTH-1:0]   r_datab;
    logic [WIDTH-1:0]   r_sig;
    logic [CNT_W-1:0]   r_vec_count;
    logic [CNT_W-1:0]   r_issue;
    logic [DRN_W-1:0]   r_drain;
    logic [LATENCY-1:0] r_pipe;
    logic               r_busy;
    logic               r_done;

    logic               w_issue_valid;
    logic               w_tap;
    logic [WIDTH-1:0]   w_next_a;
    logic [WIDTH-1:0]   w_next_b;

    assign w_issue_valid = (r_state == S_RUN);
    assign w_tap         = r_pipe[LATENCY-1];
    assign w_next_a      = r_dataa * WIDTH'(32'd1664525) + WIDTH'(32'd1013904223);
    assign w_next_b      = r_datab * WIDTH'(32'd22695477) + WIDTH'(32'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_dataa     <= '0;
            r_datab     <= '0;
            r_sig       <= '0;
            r_vec_count <= '0;
            r_issue     <= '0;
            r_drain     <= '0;
            r_pipe      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // The tap lines up with the operator output of the vector issued LATENCY cycles earlier.
            r_pipe[0] <= w_issue_valid;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end

            if (w_tap) begin
                r_sig       <= {r_sig[WIDTH-2:0], r_sig[WIDTH-1]} ^ result;
                r_vec_count <= r_vec_count + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_RUN;
                        r_dataa     <= SEED_A;
                        r_datab     <= SEED_B;
                        r_sig       <= '0;
                        r_vec_count <= '0;
                        r_issue     <= '0;
                        r_busy      <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (r_issue == CNT_W'(NUM_VECTORS - 1)) begin
                        r_state <= S_DRAIN;
                        r_drain <= '0;
                    end else begin
                        r_issue <= r_issue + 1'b1;
                        r_dataa <= w_next_a;
                        r_datab <= w_next_b;
                    end
                end
                S_DRAIN: begin
                    if (r_drain == DRN_W'(LATENCY - 1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dataa     = r_dataa;
    assign datab     = r_datab;
    assign busy      = r_busy;
    assign done      = r_done;
    assign signature = r_sig;
    assign vec_count = r_vec_count;

endmodule

// File: tb/tb_operand_feeder.sv
// Directed bench for operand_feeder: four instances (1, 2, 256 and 4-vector wrap runs)
// each driving an adder stub whose latency can be switched between 2 and 3 cycles.
module tb_operand_feeder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        st  [4];
    logic [31:0] da  [4];
    logic [31:0] db  [4];
    logic [31:0] res [4];
    logic        bz  [4];
    logic        dn  [4];
    logic [31:0] sg  [4];
    int          vcnt[4];
    int          slat[4];
    logic [31:0] pipe[4][3];

    logic [0:0]  vc0;
    logic [1:0]  vc1;
    logic [8:0]  vc2;
    logic [2:0]  vc3;

    int n_checks = 0;
    int n_pass   = 0;

    int          r_done_cyc, r_busy_cyc, r_vc;
    logic [31:0] r_sig, r_a1, r_b1, r_a2, r_b2;

    always #5 clk = ~clk;

    operand_feeder #(.NUM_VECTORS(1)) u_n1 (
        .clk(clk), .reset_n(reset_n), .start(st[0]), .dataa(da[0]), .datab(db[0]),
        .result(res[0]), .busy(bz[0]), .done(dn[0]), .signature(sg[0]), .vec_count(vc0));
    operand_feeder #(.NUM_VECTORS(2)) u_n2 (
        .clk(clk), .reset_n(reset_n), .start(st[1]), .dataa(da[1]), .datab(db[1]),
        .result(res[1]), .busy(bz[1]), .done(dn[1]), .signature(sg[1]), .vec_count(vc1));
    operand_feeder u_def (
        .clk(clk), .reset_n(reset_n), .start(st[2]), .dataa(da[2]), .datab(db[2]),
        .result(res[2]), .busy(bz[2]), .done(dn[2]), .signature(sg[2]), .vec_count(vc2));
    operand_feeder #(.NUM_VECTORS(4), .SEED_A(32'hFFFF_FFFF), .SEED_B(32'hFFFF_FFFF)) u_wrap (
        .clk(clk), .reset_n(reset_n), .start(st[3]), .dataa(da[3]), .datab(db[3]),
        .result(res[3]), .busy(bz[3]), .done(dn[3]), .signature(sg[3]), .vec_count(vc3));

    always_comb begin
        vcnt[0] = int'(vc0);
        vcnt[1] = int'(vc1);
        vcnt[2] = int'(vc2);
        vcnt[3] = int'(vc3);
    end

    // Registered adder stub; result tap chosen per instance (2 or 3 cycles).
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            pipe[i][0] <= da[i] + db[i];
            pipe[i][1] <= pipe[i][0];
            pipe[i][2] <= pipe[i][1];
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            res[i] = (slat[i] == 3) ? pipe[i][2] : pipe[i][1];
        end
    end

    function automatic logic [31:0] model_sig(input int n, input logic [31:0] a0, input logic [31:0] b0);
        logic [31:0] a, b, s;
        a = a0;
        b = b0;
        s = '0;
        for (int k = 0; k < n; k++) begin
            s = {s[30:0], s[31]} ^ (a + b);
            a = a * 32'd1664525 + 32'd1013904223;
            b = b * 32'd22695477 + 32'd1;
        end
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h (%0d), expected 0x%08h (%0d)", name, act, act, exp, exp);
    endtask

    task automatic chk_ne(input string name, input logic [31:0] act, input logic [31:0] notexp);
        n_checks++;
        if (act !== notexp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected any value other than 0x%08h", name, act, notexp);
    endtask

    // Starts a run on instance `inst`; returns in the done cycle (or after the bound expires).
    task automatic run(input int inst, input bit hold);
        @(posedge clk); #1 st[inst] = 1'b1;
        @(posedge clk); #1;
        if (!hold) st[inst] = 1'b0;
        r_done_cyc = -1;
        r_busy_cyc = 0;
        r_vc       = -1;
        r_sig      = 'x;
        for (int c = 1; c <= 600; c++) begin
            if (c == 1) begin r_a1 = da[inst]; r_b1 = db[inst]; end
            if (c == 2) begin r_a2 = da[inst]; r_b2 = db[inst]; end
            if (bz[inst]) r_busy_cyc++;
            if (dn[inst]) begin
                r_done_cyc = c;
                r_vc       = vcnt[inst];
                r_sig      = sg[inst];
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        int          inst;
        int          n;
        logic [31:0] sa, sb;
        logic [31:0] exp_a2, exp_b2;
        int          exp_done, exp_busy;
        logic [31:0] exp_sig;
    } vec_t;

    vec_t        tbl[4];
    logic [31:0] ref_def;
    int          dn_seen;

    initial begin
        for (int i = 0; i < 4; i++) begin
            st[i]   = 1'b0;
            slat[i] = 2;
        end
        ref_def = model_sig(256, 32'd1, 32'd2);
        tbl[0] = '{0,   1, 32'd1, 32'd2, 32'd1, 32'd2, 4, 3, 32'd3};
        tbl[1] = '{1,   2, 32'd1, 32'd2, 32'd1015568748, 32'd45390955, 5, 4, 32'd1060959697};
        tbl[2] = '{2, 256, 32'd1, 32'd2, 32'd1015568748, 32'd45390955, 259, 258, ref_def};
        tbl[3] = '{3,   4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1012239698, 32'd4272271820, 7, 6,
                   model_sig(4, 32'hFFFF_FFFF, 32'hFFFF_FFFF)};

        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("reset_dataa", da[i], 32'd0);
            chk("reset_busy_done_sig", {bz[i], dn[i], sg[i][29:0]}, 32'd0);
            chk("reset_vec_count", 32'(vcnt[i]), 32'd0);
        end
        reset_n = 1'b1;

        for (int t = 0; t < 4; t++) begin
            run(tbl[t].inst, 1'b0);
            chk("done_cycle", 32'(r_done_cyc), 32'(tbl[t].exp_done));
            chk("busy_cycles", 32'(r_busy_cyc), 32'(tbl[t].exp_busy));
            chk("vec_count_at_done", 32'(r_vc), 32'(tbl[t].n));
            chk("signature", r_sig, tbl[t].exp_sig);
            chk("dataa_cycle1", r_a1, tbl[t].sa);
            chk("datab_cycle1", r_b1, tbl[t].sb);
            chk("dataa_cycle2", r_a2, tbl[t].exp_a2);
            chk("datab_cycle2", r_b2, tbl[t].exp_b2);
            @(posedge clk); #1;
            chk("done_one_cycle", {31'd0, dn[tbl[t].inst]}, 32'd0);
            chk("sig_held_idle", sg[tbl[t].inst], tbl[t].exp_sig);
        end

        // start held high for a whole run: exactly one run, restart only from IDLE
        run(2, 1'b1);
        chk("hold_done_cycle", 32'(r_done_cyc), 32'd259);
        chk("hold_busy_cycles", 32'(r_busy_cyc), 32'd258);
        chk("hold_signature", r_sig, ref_def);
        @(posedge clk); #1;
        chk("hold_idle_busy_done", {30'd0, bz[2], dn[2]}, 32'd0);
        @(posedge clk); #1;
        chk("hold_restart_busy", {31'd0, bz[2]}, 32'd1);
        chk("hold_restart_dataa", da[2], 32'd1);
        st[2] = 1'b0;
        r_sig = 'x;
        for (int c = 0; c < 600; c++) begin
            if (dn[2]) begin r_sig = sg[2]; break; end
            @(posedge clk); #1;
        end
        chk("second_run_signature", r_sig, ref_def);

        // stub latency 3 against parameter 2
        slat[2] = 3;
        run(2, 1'b0);
        chk_ne("latency_mismatch_sig", r_sig, ref_def);
        chk("latency_mismatch_done", 32'(r_done_cyc), 32'd259);
        slat[2] = 2;
        repeat (2) @(posedge clk);

        // asynchronous reset in cycle 50 of a run
        @(posedge clk); #1 st[2] = 1'b1;
        @(posedge clk); #1 st[2] = 1'b0;
        repeat (49) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("rst_mid_dataa", da[2], 32'd0);
        chk("rst_mid_datab", db[2], 32'd0);
        chk("rst_mid_sig", sg[2], 32'd0);
        chk("rst_mid_busy_done_vc", {bz[2], dn[2], 30'(vcnt[2])}, 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        dn_seen = 0;
        for (int c = 0; c < 300; c++) begin
            if (dn[2]) dn_seen++;
            @(posedge clk); #1;
        end
        chk("rst_no_done", 32'(dn_seen), 32'd0);
        run(2, 1'b0);
        chk("rst_rerun_signature", r_sig, ref_def);
        chk("rst_rerun_vec_count", 32'(r_vc), 32'd256);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
